// File: rtl/clkdiv_frac_en.sv
// clkdiv_frac_en: fractional clock-enable generator.
// Emits an average of num/den clken pulses per hclkin cycle from a phase
// accumulator. The ratio can be changed at runtime through a valid/ready
// handshake. A change requested while running is held in shadow registers
// and takes effect at the next pulse, so no period is ever cut short.
// Optional feature macro: CLKDIV_FRAC_CLKOUT_EN adds the clkout toggle output.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not accumulating, acc held at 0, clken low
// RUN   | accumulating every edge with the active ratio
// PEND  | accumulating with the old ratio, new ratio waits in shadow
module clkdiv_frac_en #(
    parameter int NUM_W       = 8,
    parameter int DEN_W       = 8,
    parameter int DEFAULT_NUM = 2,
    parameter int DEFAULT_DEN = 7
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             run,
    input  logic [NUM_W-1:0] cfg_num,
    input  logic [DEN_W-1:0] cfg_den,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             cfg_pend,
`ifdef CLKDIV_FRAC_CLKOUT_EN
    output logic             clkout,
`endif
    output logic             clken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state;
    logic [DEN_W:0]   acc;
    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic [NUM_W-1:0] sh_num;
    logic [DEN_W-1:0] sh_den;

    logic [DEN_W:0]   sum;
    logic [DEN_W:0]   acc_step;
    logic             ovf;
    logic             req;
    logic             req_bad;
    logic             req_ok;
    logic             acc_en;
    logic             pulse_set;

    // Accumulate step, request decode and the "this edge emits a pulse" term.
    always_comb begin
        sum       = acc + {{(DEN_W+1-NUM_W){1'b0}}, num};
        ovf       = (sum >= {1'b0, den});
        acc_step  = ovf ? (sum - {1'b0, den}) : sum;
        req       = cfg_valid & cfg_ready;
        req_bad   = (cfg_num == '0) || (cfg_den == '0) ||
                    ({{(DEN_W+1-NUM_W){1'b0}}, cfg_num} > {1'b0, cfg_den});
        req_ok    = req & ~req_bad;
        // A valid load in IDLE restarts the phase and skips accumulation.
        acc_en    = run && ((state == RUN) || (state == PEND) ||
                            ((state == IDLE) && !req_ok));
        pulse_set = acc_en & ovf;
    end

    // Sequencer: ratio handshake, period-boundary ratio swap, registered outputs.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            acc       <= '0;
            num       <= NUM_W'(DEFAULT_NUM);
            den       <= DEN_W'(DEFAULT_DEN);
            sh_num    <= '0;
            sh_den    <= '0;
            clken     <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_pend  <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            cfg_err <= req & req_bad;
            clken   <= pulse_set;
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        num <= cfg_num;
                        den <= cfg_den;
                        acc <= '0;
                        if (run) state <= RUN;
                    end else if (run) begin
                        acc   <= acc_step;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        acc   <= '0;
                        state <= IDLE;
                        // Stopping anyway, so a valid ratio can apply at once.
                        if (req_ok) begin
                            num <= cfg_num;
                            den <= cfg_den;
                        end
                    end else begin
                        acc <= acc_step;
                        if (req_ok) begin
                            sh_num    <= cfg_num;
                            sh_den    <= cfg_den;
                            state     <= PEND;
                            cfg_pend  <= 1'b1;
                            cfg_ready <= 1'b0;
                        end
                    end
                end
                PEND: begin
                    if (!run || ovf) begin
                        num       <= sh_num;
                        den       <= sh_den;
                        acc       <= '0;
                        state     <= run ? RUN : IDLE;
                        cfg_pend  <= 1'b0;
                        cfg_ready <= 1'b1;
                    end else begin
                        acc <= acc_step;
                    end
                end
                default: begin
                    state     <= IDLE;
                    acc       <= '0;
                    cfg_pend  <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef CLKDIV_FRAC_CLKOUT_EN
    // Square-wave output: flips on every edge that launches a clken pulse.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) clkout <= 1'b0;
        else if (pulse_set) clkout <= ~clkout;
    end
`endif

endmodule

// File: tb/tb_clkdiv_frac_en.sv
// Bench for clkdiv_frac_en: ratio-level model (pulse at running edge k iff
// floor(k*num/den) advances) compared every cycle, plus literal pattern checks.
module tb_clkdiv_frac_en;

    logic       hclkin = 1'b0;
    logic       resetn;
    logic       run;
    logic [7:0] cfg_num;
    logic [7:0] cfg_den;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_err;
    logic       cfg_pend;
    logic       clken;
`ifdef CLKDIV_FRAC_CLKOUT_EN
    logic       clkout;
`endif

    int n_pass  = 0;
    int n_total = 0;

    clkdiv_frac_en #(
        .NUM_W(8), .DEN_W(8), .DEFAULT_NUM(2), .DEFAULT_DEN(7)
    ) dut (
        .hclkin    (hclkin),
        .resetn    (resetn),
        .run       (run),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cfg_pend  (cfg_pend),
`ifdef CLKDIV_FRAC_CLKOUT_EN
        .clkout    (clkout),
`endif
        .clken     (clken)
    );

    always #5 hclkin = ~hclkin;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: ratio, shadow, running/pending flags, edges since phase zero.
    int m_num, m_den, m_shn, m_shd, m_k;
    bit m_running, m_pend;
    bit e_clken, e_err, e_clkout;

    function automatic bit pulse_at(int k, int n, int d);
        return ((k * n) / d) != (((k - 1) * n) / d);
    endfunction

    always @(posedge hclkin) begin
        bit take, bad, c;
        if (!resetn) begin
            m_num = 2; m_den = 7; m_shn = 0; m_shd = 0; m_k = 0;
            m_running = 0; m_pend = 0;
            e_clken = 0; e_err = 0; e_clkout = 0;
        end else begin
            take  = cfg_valid && !m_pend;
            bad   = (cfg_num == 0) || (cfg_den == 0) || (cfg_num > cfg_den);
            e_err = take && bad;
            c     = 0;
            if (!m_running) begin
                if (take && !bad) begin
                    m_num = cfg_num; m_den = cfg_den; m_k = 0;
                    if (run) m_running = 1;
                end else if (run) begin
                    m_running = 1; m_k = 1; c = pulse_at(m_k, m_num, m_den);
                end
            end else if (!m_pend) begin
                if (!run) begin
                    m_running = 0; m_k = 0;
                    if (take && !bad) begin m_num = cfg_num; m_den = cfg_den; end
                end else begin
                    m_k++; c = pulse_at(m_k, m_num, m_den);
                    if (take && !bad) begin m_shn = cfg_num; m_shd = cfg_den; m_pend = 1; end
                end
            end else begin
                if (!run) begin
                    m_num = m_shn; m_den = m_shd; m_k = 0; m_running = 0; m_pend = 0;
                end else begin
                    m_k++; c = pulse_at(m_k, m_num, m_den);
                    if (c) begin m_num = m_shn; m_den = m_shd; m_k = 0; m_pend = 0; end
                end
            end
            e_clken = c;
            if (c) e_clkout = ~e_clkout;
        end
        #1;
        chk("clken", {31'd0, clken}, {31'd0, e_clken});
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
        chk("cfg_pend", {31'd0, cfg_pend}, {31'd0, m_pend});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, e_err});
`ifdef CLKDIV_FRAC_CLKOUT_EN
        chk("clkout", {31'd0, clkout}, {31'd0, e_clkout});
`endif
    end

    task automatic edge_s();
        @(posedge hclkin);
        #2;
    endtask

    task automatic request(input int n, input int d);
        cfg_num = 8'(n); cfg_den = 8'(d); cfg_valid = 1'b1;
        edge_s();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] pat14;
        logic [7:0]  pat8;
        logic [5:0]  pat6;
        logic [6:0]  pat7;
        int          pc;
        resetn = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_num = '0; cfg_den = '0;
        edge_s(); edge_s();
        chk("rst_clken", {31'd0, clken}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_pend", {31'd0, cfg_pend}, 32'd0);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);

        // Default 2/7 from reset: pulses after edges 4, 7, 11, 14.
        resetn = 1'b1; run = 1'b1;
        pc = 0;
        for (int i = 0; i < 14; i++) begin
            edge_s(); pat14[i] = clken; if (clken) pc++;
        end
        chk("pat_2_7", {18'd0, pat14}, 32'h2448);
        chk("cnt_2_7", pc, 32'd4);

        // 1/1 loaded in IDLE: pulse every running edge.
        run = 1'b0; edge_s();
        request(1, 1);
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_s(); pat8[i] = clken;
        end
        chk("pat_1_1", {28'd0, pat8[3:0]}, 32'hF);

        // 1/4 while running: held until the next 1/1 pulse, then every 4th edge.
        request(1, 4);
        chk("pend_1_4", {31'd0, cfg_pend}, 32'd1);
        chk("ready_1_4", {31'd0, cfg_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            edge_s(); pat8[i] = clken;
        end
        chk("pat_1_4", {24'd0, pat8}, 32'h11);

        // Invalid requests: error pulse only.
        request(0, 5);
        chk("err_0_5", {31'd0, cfg_err}, 32'd1);
        edge_s();
        chk("err_0_5_clr", {31'd0, cfg_err}, 32'd0);
        request(3, 0);
        chk("err_3_0", {31'd0, cfg_err}, 32'd1);
        edge_s();
        request(6, 5);
        chk("err_6_5", {31'd0, cfg_err}, 32'd1);
        chk("err_6_5_pend", {31'd0, cfg_pend}, 32'd0);
        edge_s();

        // 2/3 pending, then run dropped: applied immediately.
        request(2, 3);
        chk("pend_2_3", {31'd0, cfg_pend}, 32'd1);
        run = 1'b0;
        edge_s();
        chk("idle_pend", {31'd0, cfg_pend}, 32'd0);
        chk("idle_ready", {31'd0, cfg_ready}, 32'd1);
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            edge_s(); pat6[i] = clken;
        end
        chk("pat_2_3", {26'd0, pat6}, 32'h36);

        // Asynchronous reset mid-run.
        #1 resetn = 1'b0;
        #1;
        chk("arst_run_clken", {31'd0, clken}, 32'd0);
        chk("arst_run_ready", {31'd0, cfg_ready}, 32'd1);
        edge_s();
        resetn = 1'b1;
        edge_s(); edge_s();

        // Asynchronous reset mid-PEND: shadow 1/5 discarded, back to 2/7.
        request(1, 5);
        chk("pend_1_5", {31'd0, cfg_pend}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_pend_pend", {31'd0, cfg_pend}, 32'd0);
        chk("arst_pend_ready", {31'd0, cfg_ready}, 32'd1);
        chk("arst_pend_clken", {31'd0, clken}, 32'd0);
        edge_s();
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            edge_s(); pat7[i] = clken;
        end
        chk("pat_after_rst", {25'd0, pat7}, 32'h48);

`ifdef CLKDIV_FRAC_CLKOUT_EN
        // 1/2: clkout period 4 at 50% duty.
        run = 1'b0; edge_s();
        request(1, 2);
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            edge_s(); pat8[i] = clkout;
        end
        chk("clkout_1_2", {24'd0, pat8}, 32'h66);
`endif

        run = 1'b0;
        edge_s(); edge_s();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
